servile_rf_mem_arb: RTL and testbench

Next-generation arbiter that shares one single-port SRAM between the SERV register file (RF) and a 32-bit Wishbone data/instruction port.
- Generalised over SRAM data width (8/16/32), SRAM read latency (1 or 2) and RF access width.
- Adds byte-masked writes, RF preemption with beat replay, and tagged read-return routing.
- The RF occupies the highest rf_regs*4 bytes of the SRAM.
- Sits between servile_rf_ram_if and the SRAM macro.

---
 rtl/servile_mem_pkg.sv | 34 +++
 rtl/servile_rd_tag_pipe.sv | 48 ++++
 rtl/servile_rf_mem_arb.sv | 199 +++++++++++++++++++
 tb/tb_servile_rf_mem_arb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/servile_mem_pkg.sv
// Shared types and helpers for the servile RF/Wishbone SRAM arbiter.
//   state_t   : arbiter FSM states
//   rd_tag_t  : per-read routing tag {valid, is_rf, beat}
//   calc_*    : derived geometry (beats per WB access, SRAM/RF word address widths)
package servile_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Beat field sized for the narrowest SRAM (8 bit -> 4 beats).
  localparam int BEAT_W = 2;

  typedef struct packed {
    logic              valid;
    logic              is_rf;
    logic [BEAT_W-1:0] beat;
  } rd_tag_t;

  function automatic int calc_beats(input int dw);
    return 32 / dw;
  endfunction

  function automatic int calc_aw(input int depth_b, input int dw);
    return $clog2(depth_b * 8 / dw);
  endfunction

  function automatic int calc_rf_aw(input int regs, input int dw);
    return $clog2(regs * 32 / dw);
  endfunction

endpackage

// File: rtl/servile_rd_tag_pipe.sv
// Read-return tag pipeline. Carries the routing tag of every issued SRAM read,
// plus the RF "register x0" flag, for rd_lat cycles so both line up with the
// data appearing on the SRAM read port.
//   clk, rst_n      : clock, asynchronous active-low clear
//   tag_in, rz_in   : tag / regzero for the read issued this cycle
//   tag_out, rz_out : tag / regzero matching the SRAM data this cycle
module servile_rd_tag_pipe
  import servile_mem_pkg::*;
#(
  parameter int rd_lat = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  input  logic    rz_in,
  output rd_tag_t tag_out,
  output logic    rz_out
);

  rd_tag_t [rd_lat-1:0] tag_pipe;
  logic    [rd_lat-1:0] rz_pipe;

  if (rd_lat == 1) begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tag_pipe <= '0;
        rz_pipe  <= '0;
      end else begin
        tag_pipe[0] <= tag_in;
        rz_pipe[0]  <= rz_in;
      end
    end
  end else begin : g_latn
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tag_pipe <= '0;
        rz_pipe  <= '0;
      end else begin
        tag_pipe <= {tag_pipe[rd_lat-2:0], tag_in};
        rz_pipe  <= {rz_pipe[rd_lat-2:0], rz_in};
      end
    end
  end

  assign tag_out = tag_pipe[rd_lat-1];
  assign rz_out  = rz_pipe[rd_lat-1];

endmodule

// File: rtl/servile_rf_mem_arb.sv
// Shares one single-port-per-direction SRAM between the SERV register file and
// a 32-bit Wishbone port. RF traffic always wins; Wishbone accesses are split
// into 32/sram_dw beats, preempted beats are replayed, reads are tagged so the
// returning data is routed to o_rdata or the Wishbone read assembly.
//   i_clk, i_rst_n           : clock, asynchronous active-low reset
//   i_waddr/i_wdata/i_wen    : RF write
//   i_raddr/i_ren, o_rdata   : RF read, data rd_lat cycles after i_ren
//   o_sram_*, i_sram_rdata   : SRAM macro (separate read and write ports)
//   i_wb_*, o_wb_rdt/o_wb_ack: Wishbone slave, one-cycle ack pulse
module servile_rf_mem_arb
  import servile_mem_pkg::*;
#(
  parameter int depth   = 256,
  parameter int rf_regs = 32,
  parameter int sram_dw = 8,
  parameter int rd_lat  = 1,
  parameter int beats   = calc_beats(sram_dw),
  parameter int aw      = calc_aw(depth, sram_dw),
  parameter int rf_aw   = calc_rf_aw(rf_regs, sram_dw)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [rf_aw-1:0]          i_waddr,
  input  logic [sram_dw-1:0]        i_wdata,
  input  logic                      i_wen,
  input  logic [rf_aw-1:0]          i_raddr,
  input  logic                      i_ren,
  output logic [sram_dw-1:0]        o_rdata,
  output logic [aw-1:0]             o_sram_waddr,
  output logic [sram_dw-1:0]        o_sram_wdata,
  output logic [sram_dw/8-1:0]      o_sram_wmask,
  output logic                      o_sram_wen,
  output logic [aw-1:0]             o_sram_raddr,
  output logic                      o_sram_ren,
  input  logic [sram_dw-1:0]        i_sram_rdata,
  input  logic [$clog2(depth)-3:0]  i_wb_adr,
  input  logic [31:0]               i_wb_dat,
  input  logic [3:0]                i_wb_sel,
  input  logic                      i_wb_we,
  input  logic                      i_wb_stb,
  output logic [31:0]               o_wb_rdt,
  output logic                      o_wb_ack
);

  localparam int BW = (beats > 1) ? $clog2(beats) : 1;  // beat counter width
  localparam int MW = sram_dw / 8;                       // mask bits per beat
  localparam int ZB = $clog2(32 / sram_dw);              // word-within-register bits
  localparam logic [BW-1:0]     LAST     = BW'(beats - 1);
  localparam logic [BEAT_W-1:0] LAST_TAG = BEAT_W'(beats - 1);

  state_t         state;
  logic [BW-1:0]  cnt;
  logic           ack_q;
  logic           rd_ack;

  logic           rf_req, start, active, wb_issue, last;
  logic [aw-1:0]  wb_addr;
  logic [sram_dw-1:0] wb_wdata;
  logic [MW-1:0]  wb_mask;

  rd_tag_t        tag_in, tag_out;
  logic           rz_in, rz_out;

  // ---------------------------------------------------------------------
  // Issue control. The first beat goes out in the same cycle the strobe is
  // seen, so IDLE contributes to "active" combinationally. Gating with
  // i_rst_n keeps every SRAM strobe low while reset is held.
  // ---------------------------------------------------------------------
  assign rf_req   = i_wen | i_ren;
  assign start    = (state == IDLE) & i_wb_stb & ~o_wb_ack;
  assign active   = i_rst_n & (start | (state == ISSUE));
  assign wb_issue = active & ~rf_req;
  assign last     = (cnt == LAST);

  if (beats > 1) begin : g_multi_beat
    assign wb_addr = {i_wb_adr, cnt};
  end else begin : g_single_beat
    assign wb_addr = i_wb_adr;
  end

  assign wb_wdata = i_wb_dat[int'(cnt)*sram_dw +: sram_dw];
  assign wb_mask  = i_wb_sel[int'(cnt)*MW +: MW];

  // Write port: RF lands at the NOT-mapped top of memory with a full mask.
  // A Wishbone beat whose mask is empty still uses its slot but writes nothing.
  always_comb begin
    o_sram_wen   = 1'b0;
    o_sram_waddr = wb_addr;
    o_sram_wdata = wb_wdata;
    o_sram_wmask = wb_mask;
    if (i_wen) begin
      o_sram_wen   = i_rst_n;
      o_sram_waddr = ~aw'(i_waddr);
      o_sram_wdata = i_wdata;
      o_sram_wmask = '1;
    end else if (wb_issue & i_wb_we) begin
      o_sram_wen   = |wb_mask;
    end
  end

  // Read port
  always_comb begin
    o_sram_ren   = 1'b0;
    o_sram_raddr = wb_addr;
    if (i_ren) begin
      o_sram_ren   = i_rst_n;
      o_sram_raddr = ~aw'(i_raddr);
    end else if (wb_issue & ~i_wb_we) begin
      o_sram_ren   = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // FSM. The counter only advances on beats that actually reach the SRAM,
  // so a preempted beat is naturally replayed with the same address/data.
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ack_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        IDLE, ISSUE: begin
          if (active) begin
            if (wb_issue) begin
              if (last) begin
                cnt <= '0;
                if (i_wb_we) begin
                  ack_q <= 1'b1;
                  state <= IDLE;
                end else begin
                  state <= DRAIN;
                end
              end else begin
                cnt   <= cnt + BW'(1);
                state <= ISSUE;
              end
            end else begin
              state <= ISSUE;
            end
          end
        end
        DRAIN: if (rd_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Read return routing
  // ---------------------------------------------------------------------
  always_comb begin
    tag_in       = '0;
    tag_in.valid = o_sram_ren;
    tag_in.is_rf = i_ren;
    tag_in.beat[BW-1:0] = cnt;
  end

  // x0 occupies the last register slot of the RF address space.
  assign rz_in = &i_raddr[rf_aw-1:ZB];

  servile_rd_tag_pipe #(
    .rd_lat (rd_lat)
  ) u_tag_pipe (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .tag_in  (tag_in),
    .rz_in   (rz_in),
    .tag_out (tag_out),
    .rz_out  (rz_out)
  );

  logic wb_ret;
  assign wb_ret = tag_out.valid & ~tag_out.is_rf;
  // Read ack coincides with the last beat's data on the SRAM port.
  assign rd_ack = wb_ret & (tag_out.beat == LAST_TAG);

  if (beats > 1) begin : g_rdt
    logic [beats-2:0][sram_dw-1:0] rdt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        rdt_q <= '0;
      end else if (wb_ret && (tag_out.beat != LAST_TAG)) begin
        rdt_q[tag_out.beat[BW-1:0]] <= i_sram_rdata;
      end
    end

    assign o_wb_rdt = {i_sram_rdata, rdt_q};
  end else begin : g_rdt_direct
    assign o_wb_rdt = i_sram_rdata;
  end

  assign o_wb_ack = ack_q | rd_ack;
  assign o_rdata  = rz_out ? '0 : i_sram_rdata;

endmodule

// File: tb/tb_servile_rf_mem_arb.sv
module tb_servile_rf_mem_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- 8-bit SRAM, rd_lat=1 instance ----------------
  logic [6:0]  w8_waddr, r8_raddr;
  logic [7:0]  w8_wdata, r8_rdata;
  logic        w8_wen, r8_ren;
  logic [7:0]  s8_waddr, s8_raddr, s8_wdata, s8_rdata;
  logic [0:0]  s8_wmask;
  logic        s8_wen, s8_ren;
  logic [5:0]  wb8_adr;
  logic [31:0] wb8_dat, wb8_rdt;
  logic [3:0]  wb8_sel;
  logic        wb8_we, wb8_stb, wb8_ack;

  servile_rf_mem_arb #(.depth(256), .rf_regs(32), .sram_dw(8), .rd_lat(1)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_waddr(w8_waddr), .i_wdata(w8_wdata), .i_wen(w8_wen),
    .i_raddr(r8_raddr), .i_ren(r8_ren), .o_rdata(r8_rdata),
    .o_sram_waddr(s8_waddr), .o_sram_wdata(s8_wdata), .o_sram_wmask(s8_wmask),
    .o_sram_wen(s8_wen), .o_sram_raddr(s8_raddr), .o_sram_ren(s8_ren),
    .i_sram_rdata(s8_rdata),
    .i_wb_adr(wb8_adr), .i_wb_dat(wb8_dat), .i_wb_sel(wb8_sel), .i_wb_we(wb8_we),
    .i_wb_stb(wb8_stb), .o_wb_rdt(wb8_rdt), .o_wb_ack(wb8_ack)
  );

  logic [7:0] mem8 [256];
  always @(posedge clk) begin
    if (s8_wen && s8_wmask[0]) mem8[s8_waddr] <= s8_wdata;
    if (s8_ren) s8_rdata <= mem8[s8_raddr];
  end

  // ---------------- 32-bit SRAM, rd_lat=2 instance ----------------
  logic [4:0]  w32_waddr, r32_raddr;
  logic [31:0] w32_wdata, r32_rdata;
  logic        w32_wen, r32_ren;
  logic [5:0]  s32_waddr, s32_raddr;
  logic [31:0] s32_wdata, s32_rdata, s32_r1;
  logic [3:0]  s32_wmask;
  logic        s32_wen, s32_ren;
  logic [5:0]  wb32_adr;
  logic [31:0] wb32_dat, wb32_rdt;
  logic [3:0]  wb32_sel;
  logic        wb32_we, wb32_stb, wb32_ack;

  servile_rf_mem_arb #(.depth(256), .rf_regs(32), .sram_dw(32), .rd_lat(2)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_waddr(w32_waddr), .i_wdata(w32_wdata), .i_wen(w32_wen),
    .i_raddr(r32_raddr), .i_ren(r32_ren), .o_rdata(r32_rdata),
    .o_sram_waddr(s32_waddr), .o_sram_wdata(s32_wdata), .o_sram_wmask(s32_wmask),
    .o_sram_wen(s32_wen), .o_sram_raddr(s32_raddr), .o_sram_ren(s32_ren),
    .i_sram_rdata(s32_rdata),
    .i_wb_adr(wb32_adr), .i_wb_dat(wb32_dat), .i_wb_sel(wb32_sel), .i_wb_we(wb32_we),
    .i_wb_stb(wb32_stb), .o_wb_rdt(wb32_rdt), .o_wb_ack(wb32_ack)
  );

  logic [31:0] mem32 [64];
  always @(posedge clk) begin
    if (s32_wen)
      for (int b = 0; b < 4; b++)
        if (s32_wmask[b]) mem32[s32_waddr][8*b +: 8] <= s32_wdata[8*b +: 8];
    if (s32_ren) s32_r1 <= mem32[s32_raddr];
    s32_rdata <= s32_r1;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wb8(input logic [5:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic we);
    wb8_adr = adr; wb8_dat = dat; wb8_sel = sel; wb8_we = we; wb8_stb = 1'b1;
  endtask

  task automatic wb32(input logic [5:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic we);
    wb32_adr = adr; wb32_dat = dat; wb32_sel = sel; wb32_we = we; wb32_stb = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    bit got;
    int n;

    w8_waddr = '0; w8_wdata = '0; w8_wen = 0; r8_raddr = '0; r8_ren = 0;
    wb8_adr = '0; wb8_dat = '0; wb8_sel = '0; wb8_we = 0; wb8_stb = 0;
    w32_waddr = '0; w32_wdata = '0; w32_wen = 0; r32_raddr = '0; r32_ren = 0;
    wb32_adr = '0; wb32_dat = '0; wb32_sel = '0; wb32_we = 0; wb32_stb = 0;

    // reset state
    #12;
    chk("rst ack8", wb8_ack, 0);
    chk("rst wen8", s8_wen, 0);
    chk("rst ren8", s8_ren, 0);
    chk("rst ack32", wb32_ack, 0);
    cyc(); rst_n = 1;
    cyc();

    // ---- write: 4 beats, ack in cycle 4 ----
    d = 32'hA1B2C3D4;
    cyc(); wb8(6'h04, d, 4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      #1;
      chk($sformatf("wr b%0d wen", i), s8_wen, 1);
      chk($sformatf("wr b%0d addr", i), s8_waddr, 8'h10 + 8'(i));
      chk($sformatf("wr b%0d data", i), s8_wdata, d[8*i +: 8]);
      chk($sformatf("wr b%0d ack", i), wb8_ack, 0);
    end
    cyc(); #1;
    chk("wr ack", wb8_ack, 1);
    chk("wr ack-cycle wen", s8_wen, 0);
    cyc(); wb8_stb = 0; #1;
    chk("wr ack pulse", wb8_ack, 0);

    // ---- read with RF write preempting beat 2 ----
    cyc(); wb8(6'h04, 32'h0, 4'b1111, 1'b0); #1;
    chk("pre b0 ren", s8_ren, 1);
    chk("pre b0 raddr", s8_raddr, 8'h10);
    cyc(); #1;
    chk("pre b1 raddr", s8_raddr, 8'h11);
    cyc(); w8_wen = 1; w8_waddr = 7'h05; w8_wdata = 8'h5A; #1;
    chk("pre rf wen", s8_wen, 1);
    chk("pre rf waddr", s8_waddr, 8'hFA);
    chk("pre rf wdata", s8_wdata, 8'h5A);
    chk("pre rf wmask", s8_wmask, 1);
    chk("pre wb stalled", s8_ren, 0);
    cyc(); w8_wen = 0; #1;
    chk("pre b2 replay ren", s8_ren, 1);
    chk("pre b2 replay raddr", s8_raddr, 8'h12);
    cyc(); #1;
    chk("pre b3 raddr", s8_raddr, 8'h13);
    chk("pre b3 ack", wb8_ack, 0);
    cyc(); #1;
    chk("pre ack", wb8_ack, 1);
    chk("pre rdt", wb8_rdt, 32'hA1B2C3D4);
    cyc(); wb8_stb = 0; #1;
    chk("pre ack pulse", wb8_ack, 0);

    // ---- byte-masked write ----
    cyc(); wb8(6'h04, 32'h11223344, 4'b0101, 1'b1); #1;
    chk("msk b0 wen", s8_wen, 1);
    chk("msk b0 addr", s8_waddr, 8'h10);
    chk("msk b0 data", s8_wdata, 8'h44);
    cyc(); #1;
    chk("msk b1 wen", s8_wen, 0);
    cyc(); #1;
    chk("msk b2 wen", s8_wen, 1);
    chk("msk b2 addr", s8_waddr, 8'h12);
    chk("msk b2 data", s8_wdata, 8'h22);
    cyc(); #1;
    chk("msk b3 wen", s8_wen, 0);
    cyc(); #1;
    chk("msk ack", wb8_ack, 1);
    cyc(); wb8_stb = 0;

    // read back: only bytes 0 and 2 changed; ack in cycle 4
    cyc(); wb8(6'h04, 32'h0, 4'b1111, 1'b0);
    got = 0; n = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      cyc(); #1; n++;
      if (wb8_ack) got = 1;
    end
    chk("mrd ack seen", got, 1);
    chk("mrd latency", n, 4);
    chk("mrd rdt", wb8_rdt, 32'hA122C344);
    cyc(); wb8_stb = 0;

    // ---- RF reads: x0 returns zero, others pass through ----
    cyc(); w8_wen = 1; w8_waddr = 7'h7F; w8_wdata = 8'hFF; #1;
    chk("rf w x0 addr", s8_waddr, 8'h80);
    cyc(); w8_waddr = 7'h04; w8_wdata = 8'h6C;
    cyc(); w8_wen = 0; r8_ren = 1; r8_raddr = 7'h7F; #1;
    chk("rf r x0 ren", s8_ren, 1);
    chk("rf r x0 raddr", s8_raddr, 8'h80);
    cyc(); r8_raddr = 7'h04; #1;
    chk("rf r x0 data", r8_rdata, 8'h00);
    chk("rf r4 raddr", s8_raddr, 8'hFB);
    cyc(); r8_ren = 0; #1;
    chk("rf r4 data", r8_rdata, 8'h6C);

    // ---- asynchronous reset in the middle of a write ----
    cyc(); wb8(6'h08, 32'h01020304, 4'b1111, 1'b1); #1;
    chk("rst wr b0 addr", s8_waddr, 8'h20);
    cyc();
    cyc(); #1;
    chk("rst wr b2 addr", s8_waddr, 8'h22);
    #2 rst_n = 0; #1;
    chk("rst async ack", wb8_ack, 0);
    chk("rst async wen", s8_wen, 0);
    chk("rst async ren", s8_ren, 0);
    cyc(); rst_n = 1; #1;
    chk("rst fresh b0 wen", s8_wen, 1);
    chk("rst fresh b0 addr", s8_waddr, 8'h20);
    chk("rst fresh b0 data", s8_wdata, 8'h04);
    cyc(); cyc(); cyc(); #1;
    chk("rst fresh b3 addr", s8_waddr, 8'h23);
    cyc(); #1;
    chk("rst fresh ack", wb8_ack, 1);
    cyc(); wb8_stb = 0; #1;
    chk("rst fresh ack pulse", wb8_ack, 0);

    // ---- 32-bit SRAM, rd_lat=2 ----
    cyc(); wb32(6'h05, 32'hDEADBEEF, 4'b1111, 1'b1); #1;
    chk("w32 wen", s32_wen, 1);
    chk("w32 waddr", s32_waddr, 6'h05);
    chk("w32 wdata", s32_wdata, 32'hDEADBEEF);
    chk("w32 wmask", s32_wmask, 4'hF);
    cyc(); #1;
    chk("w32 ack", wb32_ack, 1);
    cyc(); wb32_stb = 0;

    cyc(); wb32(6'h04, 32'hCAFEF00D, 4'b1111, 1'b1);
    cyc();
    cyc(); wb32_stb = 0; w32_wen = 1; w32_waddr = 5'd2; w32_wdata = 32'h12345678; #1;
    chk("w32 rf waddr", s32_waddr, 6'h3D);
    cyc(); w32_wen = 0; wb32(6'h04, 32'h0, 4'b1111, 1'b0); #1;
    chk("r32 ren", s32_ren, 1);
    chk("r32 raddr", s32_raddr, 6'h04);
    cyc(); r32_ren = 1; r32_raddr = 5'd2; #1;
    chk("r32 rf ren", s32_ren, 1);
    chk("r32 rf raddr", s32_raddr, 6'h3D);
    chk("r32 ack early", wb32_ack, 0);
    cyc(); r32_ren = 0; #1;
    chk("r32 ack", wb32_ack, 1);
    chk("r32 rdt", wb32_rdt, 32'hCAFEF00D);
    cyc(); wb32_stb = 0; #1;
    chk("r32 ack pulse", wb32_ack, 0);
    chk("r32 rf rdata", r32_rdata, 32'h12345678);
    cyc(); r32_ren = 1; r32_raddr = 5'd31;
    cyc(); r32_ren = 0;
    cyc(); #1;
    chk("r32 x0 rdata", r32_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
